mem_arbiter: RTL

//   Shares the single unified memory between the I-cache and D-cache miss paths.

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory port between the I-cache and D-cache miss paths.
// Optional macro ARB_RR_EN: round-robin tie-break (default build: D side always wins a tie).
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_busy,
  input  logic              dc_req,
  input  logic              dc_wr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_done,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_busy,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D} state_t;

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, nextState;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic              wrQ;
  logic [DATA_W-1:0] icRdataQ, dcRdataQ;
  logic              grantI, grantD;
  logic              lastBeat;

`ifdef ARB_RR_EN
  logic lastGrantD;

  always_comb begin
    grantD = dc_req && (!ic_req || !lastGrantD);
    grantI = ic_req && !grantD;
  end

  always_ff @(posedge clk) begin
    if (rst)                     lastGrantD <= 1'b0;
    else if (state == ISSUE_I)   lastGrantD <= 1'b0;
    else if (state == ISSUE_D)   lastGrantD <= 1'b1;
  end
`else
  always_comb begin
    grantD = dc_req;
    grantI = ic_req && !dc_req;
  end
`endif

  assign lastBeat = (cnt == LAT_CNT);

  always_ff @(posedge clk) begin
    // NOTE: all flops are written with <= so every reader sees the pre-edge value.
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    // NOTE: every output is defaulted first so no path through the case infers a latch.
    nextState = state;
    mem_en    = 1'b0;
    ic_done   = 1'b0;
    dc_done   = 1'b0;
    ic_busy   = 1'b0;
    dc_busy   = 1'b0;
    case (state)
      IDLE: begin
        if (grantD)      nextState = ISSUE_D;
        else if (grantI) nextState = ISSUE_I;
      end
      ISSUE_I: begin
        mem_en    = 1'b1;
        ic_busy   = 1'b1;
        nextState = WAIT_I;
      end
      ISSUE_D: begin
        mem_en    = 1'b1;
        dc_busy   = 1'b1;
        nextState = WAIT_D;
      end
      WAIT_I: begin
        ic_busy = 1'b1;
        if (lastBeat) begin
          ic_done   = 1'b1;
          nextState = IDLE;
        end
      end
      WAIT_D: begin
        dc_busy = 1'b1;
        if (lastBeat) begin
          dc_done   = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Read data is forwarded straight from memory in the done cycle, then held.
  assign ic_rdata = ic_done ? mem_rdata : icRdataQ;
  assign dc_rdata = dc_done ? (wrQ ? '0 : mem_rdata) : dcRdataQ;

  assign mem_addr  = addrQ;
  assign mem_wdata = wdataQ;
  assign mem_wr    = wrQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      addrQ    <= '0;
      wdataQ   <= '0;
      wrQ      <= 1'b0;
      icRdataQ <= '0;
      dcRdataQ <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (grantD) begin
            addrQ  <= dc_addr;
            wdataQ <= dc_wdata;
            wrQ    <= dc_wr;
          end else if (grantI) begin
            addrQ <= ic_addr;
            wrQ   <= 1'b0;
          end
        end
        ISSUE_I, ISSUE_D: cnt <= CNT_W'(1);
        WAIT_I, WAIT_D: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
      if (ic_done) icRdataQ <= ic_rdata;
      if (dc_done) dcRdataQ <= dc_rdata;
    end
  end

endmodule
